// File: rtl/axis_stat_decoder.sv
// Decodes a byte-serial AXI-Stream stat frame (tag, tick, byte, frame fields, MSB first) into parallel result fields.
// Latency: result fields and m_valid register one cycle after the tlast byte is accepted; error pulses likewise.
// Backpressure: s_axis_tready drops while a result is held unconsumed (m_valid && !m_ready); accepting nothing freezes all state.
module axis_stat_decoder #(
  parameter int TAG_ENABLE         = 1,
  parameter int TAG_WIDTH          = 16,
  parameter int TICK_COUNT_ENABLE  = 1,
  parameter int BYTE_COUNT_ENABLE  = 1,
  parameter int FRAME_COUNT_ENABLE = 1,
  parameter int TICK_COUNT_WIDTH   = 32,
  parameter int BYTE_COUNT_WIDTH   = 32,
  parameter int FRAME_COUNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tuser,
  output logic [TAG_WIDTH-1:0]         m_tag,
  output logic [TICK_COUNT_WIDTH-1:0]  m_tick_count,
  output logic [BYTE_COUNT_WIDTH-1:0]  m_byte_count,
  output logic [FRAME_COUNT_WIDTH-1:0] m_frame_count,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         error_short,
  output logic                         error_long,
  output logic                         error_bad
);

  // Bits each field occupies in the frame (0 when the field is absent).
  localparam int TAG_BITS   = (TAG_ENABLE != 0)         ? TAG_WIDTH         : 0;
  localparam int TICK_BITS  = (TICK_COUNT_ENABLE != 0)  ? TICK_COUNT_WIDTH  : 0;
  localparam int BYTE_BITS  = (BYTE_COUNT_ENABLE != 0)  ? BYTE_COUNT_WIDTH  : 0;
  localparam int FRAME_BITS = (FRAME_COUNT_ENABLE != 0) ? FRAME_COUNT_WIDTH : 0;

  localparam int SR_W        = TAG_BITS + TICK_BITS + BYTE_BITS + FRAME_BITS;
  localparam int TOTAL_BYTES = SR_W / 8;
  localparam int PTR_W       = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TOTAL_BYTES - 1);

  // The last field received sits at the LSBs of the shift register.
  localparam int FRAME_OFF = 0;
  localparam int BYTE_OFF  = FRAME_OFF + FRAME_BITS;
  localparam int TICK_OFF  = BYTE_OFF + BYTE_BITS;
  localparam int TAG_OFF   = TICK_OFF + TICK_BITS;

  typedef enum logic {ST_RX, ST_DROP} state_t;

  state_t                         state;
  logic [PTR_W-1:0]               ptr;
  logic [SR_W-1:0]                sr;
  logic [SR_W-1:0]                sr_next;
  logic                           accept;
  logic [TAG_WIDTH-1:0]           tag_nxt;
  logic [TICK_COUNT_WIDTH-1:0]    tick_nxt;
  logic [BYTE_COUNT_WIDTH-1:0]    byte_nxt;
  logic [FRAME_COUNT_WIDTH-1:0]   frame_nxt;

  assign s_axis_tready = !(m_valid && !m_ready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Shift register contents including the byte being offered this cycle.
  always_comb begin
    sr_next = SR_W'({sr, s_axis_tdata});
  end

  // Field extraction from the completed frame; absent fields decode as constant zero.
  generate
    if (TAG_ENABLE != 0) begin : g_tag
      assign tag_nxt = sr_next[TAG_OFF +: TAG_WIDTH];
    end else begin : g_no_tag
      assign tag_nxt = '0;
    end
    if (TICK_COUNT_ENABLE != 0) begin : g_tick
      assign tick_nxt = sr_next[TICK_OFF +: TICK_COUNT_WIDTH];
    end else begin : g_no_tick
      assign tick_nxt = '0;
    end
    if (BYTE_COUNT_ENABLE != 0) begin : g_byte
      assign byte_nxt = sr_next[BYTE_OFF +: BYTE_COUNT_WIDTH];
    end else begin : g_no_byte
      assign byte_nxt = '0;
    end
    if (FRAME_COUNT_ENABLE != 0) begin : g_frame
      assign frame_nxt = sr_next[FRAME_OFF +: FRAME_COUNT_WIDTH];
    end else begin : g_no_frame
      assign frame_nxt = '0;
    end
  endgenerate

  // Receive/drop FSM with registered result fields, result handshake and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RX;
      ptr           <= '0;
      sr            <= '0;
      m_tag         <= '0;
      m_tick_count  <= '0;
      m_byte_count  <= '0;
      m_frame_count <= '0;
      m_valid       <= 1'b0;
      error_short   <= 1'b0;
      error_long    <= 1'b0;
      error_bad     <= 1'b0;
    end else begin
      error_short <= 1'b0;
      error_long  <= 1'b0;
      error_bad   <= 1'b0;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (accept) begin
        case (state)
          ST_RX: begin
            sr <= sr_next;
            if (s_axis_tlast) begin
              ptr <= '0;
              if (ptr == PTR_LAST) begin
                if (s_axis_tuser) begin
                  error_bad <= 1'b1;
                end else begin
                  // A fresh result overrides the consume-clear above.
                  m_tag         <= tag_nxt;
                  m_tick_count  <= tick_nxt;
                  m_byte_count  <= byte_nxt;
                  m_frame_count <= frame_nxt;
                  m_valid       <= 1'b1;
                end
              end else begin
                error_short <= 1'b1;
              end
            end else if (ptr == PTR_LAST) begin
              error_long <= 1'b1;
              ptr        <= '0;
              state      <= ST_DROP;
            end else begin
              ptr <= ptr + PTR_W'(1);
            end
          end
          ST_DROP: begin
            if (s_axis_tlast) begin
              state <= ST_RX;
            end
          end
          default: begin
            state <= ST_RX;
            ptr   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_stat_decoder.sv
// Self-checking bench for axis_stat_decoder with default parameters (14-byte frames).
// Frame-level reference model collects accepted bytes per frame and judges each frame when it ends.
// Directed scenarios pin the model with literal expectations, then randomized frames run against it.
module tb_axis_stat_decoder;

  localparam int NB = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [15:0] m_tag;
  logic [31:0] m_tick_count, m_byte_count, m_frame_count;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        error_short, error_long, error_bad;

  int checks = 0;
  int errors = 0;

  axis_stat_decoder dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_tag(m_tag), .m_tick_count(m_tick_count), .m_byte_count(m_byte_count),
    .m_frame_count(m_frame_count), .m_valid(m_valid), .m_ready(m_ready),
    .error_short(error_short), .error_long(error_long), .error_bad(error_bad)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  q[$];
  bit          dropping = 0;
  bit          e_valid = 0, e_short = 0, e_long = 0, e_bad = 0;
  logic [15:0] e_tag = '0;
  logic [31:0] e_tick = '0, e_byte = '0, e_frame = '0;
  bit          chk_en = 0;

  function automatic logic [31:0] field(input int off, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(q[off + i]);
    return v;
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      q.delete();
      dropping = 0;
      e_valid = 0; e_short = 0; e_long = 0; e_bad = 0;
      e_tag = '0; e_tick = '0; e_byte = '0; e_frame = '0;
    end else begin
      e_short = 0; e_long = 0; e_bad = 0;
      acc = s_axis_tvalid && !(e_valid && !m_ready);
      if (e_valid && m_ready) e_valid = 0;
      if (acc) begin
        if (dropping) begin
          if (s_axis_tlast) dropping = 0;
        end else begin
          q.push_back(s_axis_tdata);
          if (s_axis_tlast) begin
            if (q.size() == NB) begin
              if (s_axis_tuser) e_bad = 1;
              else begin
                e_tag   = 16'(field(0, 2));
                e_tick  = field(2, 4);
                e_byte  = field(6, 4);
                e_frame = field(10, 4);
                e_valid = 1;
              end
            end else begin
              e_short = 1;
            end
            q.delete();
          end else if (q.size() == NB) begin
            e_long = 1;
            dropping = 1;
            q.delete();
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model, plus pulse counters.
  int cnt_short = 0, cnt_long = 0, cnt_bad = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("tready",  32'(s_axis_tready), 32'(!(e_valid && !m_ready)));
      check("m_valid", 32'(m_valid), 32'(e_valid));
      check("err_short", 32'(error_short), 32'(e_short));
      check("err_long",  32'(error_long),  32'(e_long));
      check("err_bad",   32'(error_bad),   32'(e_bad));
      check("m_tag",   32'(m_tag), 32'(e_tag));
      check("m_tick",  m_tick_count, e_tick);
      check("m_byte",  m_byte_count, e_byte);
      check("m_frame", m_frame_count, e_frame);
      if (error_short === 1'b1) cnt_short++;
      if (error_long === 1'b1)  cnt_long++;
      if (error_bad === 1'b1)   cnt_bad++;
    end
  end

  // Random m_ready when enabled.
  bit rdy_rand = 0;
  always begin
    @(posedge clk);
    #1;
    if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus ----------------
  logic [7:0] fr [0:17];
  bit gaps = 0;

  task automatic load_std();
    logic [7:0] s [0:13];
    s = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 14; i++) fr[i] = s[i];
    for (int i = 14; i < 18; i++) fr[i] = 8'hEE;
  endtask

  task automatic load_rand();
    for (int i = 0; i < 18; i++) fr[i] = 8'($urandom);
  endtask

  // Called in the posedge+2 phase; returns in the posedge+2 phase after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input bit last, input bit user);
    bit hs;
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end
    s_axis_tdata = d; s_axis_tlast = last; s_axis_tuser = user; s_axis_tvalid = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 2000) begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk);
      #2;
      n++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL send_byte: handshake timeout, got tready=0 expected 1 within 2000 cycles");
    end
  endtask

  task automatic send_frame(input int n, input bit bad);
    for (int i = 0; i < n; i++) send_byte(fr[i], i == n - 1, bad && (i == n - 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    int s0, l0, b0;
    // reset
    rst = 1'b1;
    @(posedge clk); #2;
    chk_en = 1;
    idle(2);
    rst = 1'b0;
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_tready", 32'(s_axis_tready), 32'h1);
    check("rst_m_tag", 32'(m_tag), 32'h0);
    check("rst_frame", m_frame_count, 32'h0);
    idle(1);

    // standard frame, m_ready high
    m_ready = 1'b1;
    load_std();
    send_frame(14, 0);
    check("std_valid", 32'(m_valid), 32'h1);
    check("std_tag", 32'(m_tag), 32'h1234);
    check("std_tick", m_tick_count, 32'h100);
    check("std_byte", m_byte_count, 32'h40);
    check("std_frame", m_frame_count, 32'h1);
    check("model_tag", 32'(e_tag), 32'h1234);
    check("model_tick", e_tick, 32'h100);
    idle(3);

    // backpressure: result held, second frame stalls until m_ready
    m_ready = 1'b0;
    send_frame(14, 0);
    check("bp_valid", 32'(m_valid), 32'h1);
    fork
      begin
        fr[0] = 8'hAB; fr[1] = 8'hCD; fr[13] = 8'h07;
        send_frame(14, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #3;
        check("bp_tready", 32'(s_axis_tready), 32'h0);
        check("bp_hold_tag", 32'(m_tag), 32'h1234);
        check("bp_hold_frame", m_frame_count, 32'h1);
        m_ready = 1'b1;
      end
    join
    check("bp2_valid", 32'(m_valid), 32'h1);
    check("bp2_tag", 32'(m_tag), 32'hABCD);
    check("bp2_frame", m_frame_count, 32'h7);
    idle(2);

    // short frame then good frame
    load_std();
    s0 = cnt_short;
    send_frame(5, 0);
    check("short_pulse", 32'(error_short), 32'h1);
    check("short_valid", 32'(m_valid), 32'h0);
    idle(2);
    check("short_count", 32'(cnt_short - s0), 32'h1);
    send_frame(14, 0);
    check("after_short_tag", 32'(m_tag), 32'h1234);
    idle(2);

    // long frame then good frame
    l0 = cnt_long; s0 = cnt_short;
    send_frame(16, 0);
    check("long_valid", 32'(m_valid), 32'h0);
    check("long_count", 32'(cnt_long - l0), 32'h1);
    check("long_no_short", 32'(cnt_short - s0), 32'h0);
    send_frame(14, 0);
    check("after_long_byte", m_byte_count, 32'h40);
    check("after_long_valid", 32'(m_valid), 32'h1);
    idle(2);

    // bad frame
    b0 = cnt_bad;
    send_frame(14, 1);
    check("bad_pulse", 32'(error_bad), 32'h1);
    check("bad_valid", 32'(m_valid), 32'h0);
    idle(2);
    check("bad_count", 32'(cnt_bad - b0), 32'h1);

    // reset mid-frame
    for (int i = 0; i < 7; i++) send_byte(fr[i], 0, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    s0 = cnt_short; l0 = cnt_long; b0 = cnt_bad;
    send_frame(14, 0);
    check("rst_mid_tick", m_tick_count, 32'h100);
    check("rst_mid_valid", 32'(m_valid), 32'h1);
    idle(2);
    check("rst_mid_no_err", 32'((cnt_short - s0) + (cnt_long - l0) + (cnt_bad - b0)), 32'h0);

    // randomized frames
    gaps = 1;
    rdy_rand = 1;
    for (int f = 0; f < 250; f++) begin
      int n;
      load_rand();
      n = ($urandom_range(0, 9) < 6) ? 14 : int'($urandom_range(1, 18));
      send_frame(n, $urandom_range(0, 4) == 0);
    end
    rdy_rand = 0;
    gaps = 0;
    m_ready = 1'b1;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_stat_decoder.md
AXIS_STAT_DECODER -- requirements
Module: axis_stat_decoder

Interface
REQ-001 SHALL have parameter TAG_ENABLE, default 1, meaning the tag field is present in the frame.
REQ-002 SHALL have parameter TAG_WIDTH, default 16, meaning the tag width in bits; it SHALL be a multiple of 8.
REQ-003 SHALL have parameters TICK_COUNT_ENABLE, BYTE_COUNT_ENABLE and FRAME_COUNT_ENABLE, each default 1, each meaning that field is present.
REQ-004 SHALL have parameters TICK_COUNT_WIDTH, BYTE_COUNT_WIDTH and FRAME_COUNT_WIDTH, each default 32, each a multiple of 8 and giving the field width in bits.
REQ-005 SHALL define TOTAL_BYTES as the sum of enabled field widths divided by 8; TOTAL_BYTES of 0 is illegal.
REQ-006 clk  input  1  sole clock; all logic on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 s_axis_tdata  input  8  stat frame byte.
REQ-009 s_axis_tvalid  input  1 / s_axis_tready  output  1 / s_axis_tlast  input  1 / s_axis_tuser  input  1  AXI-Stream input handshake, frame end and bad-frame flag.
REQ-010 m_tag  output  TAG_WIDTH  decoded tag.
REQ-011 m_tick_count, m_byte_count, m_frame_count  output  respective widths  decoded counters.
REQ-012 m_valid  output  1 / m_ready  input  1  result handshake.
REQ-013 error_short, error_long, error_bad  output  1 each  single-cycle error pulses.

Function
REQ-014 Frame layout SHALL be enabled fields in the order tag, tick, byte, frame, each field most-significant byte first, one byte per beat, with tlast on byte TOTAL_BYTES.
REQ-015 A disabled field's output SHALL be constant 0.
REQ-016 s_axis_tready SHALL equal !(m_valid && !m_ready).
REQ-017 A byte is accepted when s_axis_tvalid && s_axis_tready; nothing changes on cycles without acceptance.
REQ-018 States: RX and DROP. RX holds a byte pointer 0..TOTAL_BYTES-1 and a TOTAL_BYTES*8-bit shift register that shifts left 8 bits, inserting each accepted byte at the LSBs.
REQ-019 In RX, when a byte with tlast is accepted at pointer TOTAL_BYTES-1 and tuser=0, the outputs SHALL load from the shift register including that byte, m_valid SHALL be 1 on the next cycle, and the pointer SHALL return to 0.
REQ-020 The same case with tuser=1 SHALL discard the frame, pulse error_bad on the next cycle, and leave m_valid unchanged.
REQ-021 In RX, a tlast byte accepted at pointer < TOTAL_BYTES-1 SHALL discard the frame, pulse error_short, and reset the pointer to 0; tuser is ignored in this case.
REQ-022 In RX, a non-tlast byte accepted at pointer TOTAL_BYTES-1 SHALL pulse error_long, discard the frame, and enter DROP.
REQ-023 DROP SHALL accept and discard bytes, then return to RX with pointer 0 after accepting a tlast byte; no further error pulse is issued.
REQ-024 m_valid SHALL clear on m_valid && m_ready unless a new result loads in the same cycle, in which case it SHALL stay 1 with the new data.
REQ-025 Outputs SHALL be held stable while m_valid && !m_ready.
REQ-026 The pointer SHALL never exceed TOTAL_BYTES-1.
REQ-027 Error pulses SHALL be mutually exclusive and last exactly one cycle.

Reset
REQ-028 When rst=1 at a clock edge, the state SHALL become RX; pointer, shift register, all m_* fields, m_valid and error pulses SHALL be 0; s_axis_tready SHALL be 1 on the following cycle.
REQ-029 Reset mid-frame SHALL discard the partial frame; the next accepted byte is byte 1 of a new frame.

Verification
REQ-030 Defaults, bytes 12 34 / 00 00 01 00 / 00 00 00 40 / 00 00 00 01, tlast on byte 14, m_ready=1 -> next cycle m_valid=1, m_tag=0x1234, tick=0x100, byte=0x40, frame=1.
REQ-031 Same frame with m_ready=0, then a second frame offered -> s_axis_tready=0 and outputs held; after m_ready=1 the second frame decodes correctly.
REQ-032 tlast on byte 5 -> error_short for 1 cycle, no m_valid; the following good frame decodes correctly.
REQ-033 16-byte frame with tlast on byte 16 -> error_long after byte 14, bytes 15-16 dropped; the following good frame decodes.
REQ-034 Good-length frame with tuser=1 on the last byte -> error_bad, m_valid stays 0.
REQ-035 rst pulse after byte 7, then a full good frame -> correct decode and no error pulses.
